// File: rtl/obi_mem_responder_pkg.sv
// obi_mem_responder_pkg
// Shared types and constants for the data-memory responder: FSM state
// encoding, counter width, and the default memory window used both by the
// responder and by the cache benches that talk to it.
package obi_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_WAIT = 2'd1,
    RESP     = 2'd2
  } state_e;

  // Grant-delay and response-latency counters; both parameters are 0..15.
  localparam int CNT_W = 4;

  localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h0010_0000;
  localparam int          DEFAULT_DEPTH_WORDS = 1024;

endpackage

// File: rtl/obi_mem_responder_if.sv
// obi_mem_responder_if
// Core-data req/gnt/rvalid bus between a requester (cache or core) and a
// memory responder.
//   req_i    request valid               (master -> slave)
//   addr_i   byte address, [1:0] ignored (master -> slave)
//   we_i     1 = write, 0 = read         (master -> slave)
//   be_i     write byte enables          (master -> slave)
//   wdata_i  write data                  (master -> slave)
//   gnt_o    request accepted            (slave -> master)
//   rvalid_o response valid pulse        (slave -> master)
//   rdata_o  read data, with rvalid_o    (slave -> master)
//   err_o    out-of-window, with rvalid_o(slave -> master)
interface obi_mem_responder_if;
  logic        req_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/obi_mem_responder_sp_ram_be.sv
// sp_ram_be
// Single-port synchronous RAM, DEPTH_WORDS x 32, per-byte write enable and
// registered read. The array has no reset so it maps onto block RAM; only the
// output register is reset.
//   clk    clock
//   rst_n  asynchronous active-low reset of the read register
//   we     write strobe (bytes selected by be)
//   re     read strobe; when low the read register returns to zero
//   be     byte enables for writes
//   addr   word index
//   wdata  write data
//   rdata  registered read data
module sp_ram_be #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // The read register doubles as the bus rdata register: it carries data only
  // in the response cycle and is zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/obi_mem_responder.sv
// obi_mem_responder
// Memory-side responder for the core-data req/gnt/rvalid protocol. Backs a
// byte-writable SRAM window at BASE_ADDR with GNT_DELAY grant delay and
// RVALID_LATENCY response latency; accesses outside the window respond with
// err_o. At most one transaction is outstanding.
//   clk     clock
//   rst_n   asynchronous active-low reset
//   mem_if  slave side of obi_mem_responder_if (req/addr/we/be/wdata in,
//           gnt/rvalid/rdata/err out)
module obi_mem_responder
  import obi_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_WORDS    = DEFAULT_DEPTH_WORDS,
  parameter int          GNT_DELAY      = 0,
  parameter int          RVALID_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  obi_mem_responder_if.slave mem_if
);

  localparam int               AW       = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] GNT_D    = CNT_W'(GNT_DELAY);
  localparam logic [CNT_W-1:0] LAT_D    = CNT_W'(RVALID_LATENCY);
  localparam logic [32:0]      BASE_EXT = {1'b0, BASE_ADDR};
  localparam logic [32:0]      LIM_EXT  = BASE_EXT + (33'(DEPTH_WORDS) << 2);
  localparam logic [AW-1:0]    BASE_IDX = BASE_ADDR[AW+1:2];

  state_e           state_q;
  logic [CNT_W-1:0] gcnt_q;
  logic [CNT_W-1:0] lcnt_q;
  logic             gnt_q;
  logic             pend_rd_p0;
  logic             pend_err_p0;
  logic [AW-1:0]    idx_p0;
  logic             rvalid_p1;
  logic             err_p1;

  logic             idle_like;
  logic             gnt;
  logic             grant;
  logic             hit;
  logic             lat_next;
  logic [AW-1:0]    idx_in;
  logic [AW-1:0]    ram_addr;
  logic             ram_we;
  logic             ram_re;
  logic [31:0]      ram_rdata;

  // The rvalid cycle of RESP accepts new requests exactly like IDLE.
  assign idle_like = (state_q == IDLE) || rvalid_p1;

  // Zero delay grants combinationally; otherwise gnt is a registered pulse.
  assign gnt   = (GNT_DELAY == 0) ? (mem_if.req_i && idle_like) : gnt_q;
  assign grant = gnt && mem_if.req_i;

  // 33-bit compare so a window ending at 2^32 cannot wrap.
  assign hit    = ({1'b0, mem_if.addr_i} >= BASE_EXT) && ({1'b0, mem_if.addr_i} < LIM_EXT);
  assign idx_in = mem_if.addr_i[AW+1:2] - BASE_IDX;

  // Last non-valid RESP cycle: the response registers load at its end.
  assign lat_next = (state_q == RESP) && !rvalid_p1 && (lcnt_q + ONE == LAT_D);

  // Writes commit at the grant edge. Reads are taken at the edge that enters
  // the rvalid cycle; no grant can occur in between, so the word equals the
  // one present at the grant edge, and the RAM register becomes rdata_o.
  assign ram_addr = grant ? idx_in : idx_p0;
  assign ram_we   = grant && mem_if.we_i && hit;
  assign ram_re   = grant ? ((RVALID_LATENCY == 1) && !mem_if.we_i && hit)
                          : (lat_next && pend_rd_p0);

  sp_ram_be #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .re    (ram_re),
    .be    (mem_if.be_i),
    .addr  (ram_addr),
    .wdata (mem_if.wdata_i),
    .rdata (ram_rdata)
  );

  // Grant stage: capture the word index of the accepted request.
  always_ff @(posedge clk) begin
    if (grant) begin
      idx_p0 <= idx_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gcnt_q      <= '0;
      lcnt_q      <= '0;
      gnt_q       <= 1'b0;
      pend_rd_p0  <= 1'b0;
      pend_err_p0 <= 1'b0;
      rvalid_p1   <= 1'b0;
      err_p1      <= 1'b0;
    end else begin
      rvalid_p1 <= 1'b0;
      err_p1    <= 1'b0;
      gnt_q     <= 1'b0;
      if (grant) begin
        state_q     <= RESP;
        gcnt_q      <= '0;
        lcnt_q      <= ONE;
        pend_rd_p0  <= hit && !mem_if.we_i;
        pend_err_p0 <= !hit;
        // Response stage: with latency 1 the response follows the grant edge.
        if (RVALID_LATENCY == 1) begin
          rvalid_p1 <= 1'b1;
          err_p1    <= !hit;
        end
      end else if (idle_like) begin
        lcnt_q <= '0;
        if (mem_if.req_i) begin
          state_q <= GNT_WAIT;
          gcnt_q  <= ONE;
          gnt_q   <= (GNT_D == ONE);
        end else begin
          state_q <= IDLE;
          gcnt_q  <= '0;
        end
      end else if (state_q == GNT_WAIT) begin
        if (!mem_if.req_i) begin
          // Requester withdrew before grant: abandon without a transaction.
          state_q <= IDLE;
          gcnt_q  <= '0;
        end else begin
          gcnt_q <= gcnt_q + ONE;
          gnt_q  <= (gcnt_q + ONE == GNT_D);
        end
      end else begin
        // Response stage: count toward the rvalid cycle.
        lcnt_q <= lcnt_q + ONE;
        if (lat_next) begin
          rvalid_p1 <= 1'b1;
          err_p1    <= pend_err_p0;
        end
      end
    end
  end

  assign mem_if.gnt_o    = gnt;
  assign mem_if.rvalid_o = rvalid_p1;
  assign mem_if.err_o    = err_p1;
  assign mem_if.rdata_o  = ram_rdata;

endmodule

// File: doc/obi_mem_responder.md
# obi_mem_responder

Memory-side responder for the core-data req/gnt/rvalid protocol: the slave end a data cache or core drives through its `mem_*` port. Backs a word-addressed, byte-writable SRAM window with programmable grant delay and read latency. Used as the on-chip data memory behind the cache and as the reference slave in cache benches. Out-of-window accesses are answered with an error flag.

## Interface
- `BASE_ADDR`, 32'h0010_0000, byte address of word 0; 4-byte aligned
- `DEPTH_WORDS`, 1024, number of 32-bit words; power of two, ≥ 2
- `GNT_DELAY`, 0, req-high cycles before gnt; 0..15
- `RVALID_LATENCY`, 1, cycles from grant cycle to rvalid; 1..15

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `req_i`  in  1  request valid
- `addr_i`  in  32  byte address; bits [1:0] ignored
- `we_i`  in  1  1 = write, 0 = read
- `be_i`  in  4  write byte enables; bit n covers wdata[8n+7:8n]
- `wdata_i`  in  32  write data
- `gnt_o`  out  1  request accepted this cycle
- `rvalid_o`  out  1  response valid, one-cycle pulse
- `rdata_o`  out  32  read data, meaningful only with rvalid_o
- `err_o`  out  1  access outside window, qualified by rvalid_o

## Operation
- States: IDLE (nothing pending, gnt counter cleared), GNT_WAIT (req_i held, counting), RESP (one transaction outstanding, latency counter running).
- IDLE: req_i=1 and GNT_DELAY=0 → gnt_o=req_i combinationally, go RESP; GNT_DELAY>0 → GNT_WAIT, counter=1.
- GNT_WAIT: req_i=1 → counter+1; gnt_o=1 in the cycle counter==GNT_DELAY, then go RESP. req_i=0 (protocol violation) → back to IDLE, counter cleared, no transaction.
- Grant cycle T: addr/we/be/wdata sampled at the edge ending T. In-window write commits to RAM at that edge, only enabled bytes. In-window read captures RAM word at the same edge (read-after-write across back-to-back transactions returns new data).
- Window: hit iff BASE_ADDR ≤ addr_i < BASE_ADDR + 4·DEPTH_WORDS; index = (addr_i − BASE_ADDR)[log2(DEPTH_WORDS)+1:2]; compare in 33 bits, no wrap at 2^32.
- Miss: write dropped, read returns 32'h0, err_o=1 with rvalid_o.
- Writes: rdata_o = 32'h0 with rvalid_o.
- RESP: counter counts to RVALID_LATENCY; rvalid_o=1 for exactly that cycle; rdata_o/err_o held from T, 0 otherwise.
- At most one outstanding transaction. gnt_o=0 in RESP except in the rvalid_o cycle, where the state behaves as IDLE (new req may be granted same cycle if GNT_DELAY=0, or starts GNT_WAIT).
- be_i=4'b0000 write: legal, no RAM change, normal response.

## Timing
- Reset (async assert, sync-to-clk deassert by the system): state IDLE, counters 0, gnt_o=0, rvalid_o=0, rdata_o=32'h0, err_o=0. RAM contents not reset.
- Reset mid-transaction: pending response dropped, no rvalid after release. A write granted before the reset edge stays committed.
- Grant latency: GNT_DELAY cycles after first req_i-high cycle (0 = same cycle).
- Response latency: rvalid_o in cycle T+RVALID_LATENCY.
- Throughput with GNT_DELAY=0: one transaction per RVALID_LATENCY cycles. Latency=1 gives one per cycle.
- Inputs are don't-care except in grant cycles. Outputs glitch-free: registered, except gnt_o when GNT_DELAY=0.

## Structure
- Package `obi_mem_responder_pkg`: state enum (IDLE, GNT_WAIT, RESP), 4-bit counter width, default BASE_ADDR/DEPTH_WORDS constants shared with the cache bench.
- Sub-module `sp_ram_be`: single-port synchronous RAM, DEPTH_WORDS×32, per-byte write enable, registered read. FPGA block-RAM inferable; no reset on the array.
- Top holds the FSM, window decode, counters and response registers.

## Test plan
- Reset release → all outputs 0. Assert rst_n=0 during RESP (latency 4) → no rvalid after release.
- GNT_DELAY=0, latency=1: write 32'hDEADBEEF to 0x0010_0010 be=4'hF, then read same address back-to-back → gnt both cycles, rvalid on the next cycles, read returns 32'hDEADBEEF, err_o=0.
- Byte enables: preload 32'h11223344, write 32'hAABBCCDD be=4'b0101 → readback 32'h11BB33DD.
- GNT_DELAY=3, latency=2: req held → gnt in 4th req cycle, rvalid 2 cycles later. Drop req after 2 cycles → no gnt, FSM back to IDLE.
- Out of window: read 0x0010_1000 (DEPTH 1024) → rvalid with err_o=1, rdata 32'h0. Write 0x000F_FFFC → err_o=1, RAM word 0 and last word unchanged.
- Latency=3 with req held continuously → gnt only in cycles where rvalid_o=1 (plus first), never two outstanding.
